// File: rtl/lattice_result_collector.sv
// Result collector after the last lattice core: finds the first winning
// nonce per block (or flags exhaustion) and queues one record per block.
// Ports:
//   clk, rst            - clock, async active-high reset
//   valid_i             - hash result presented this cycle
//   newblock_i          - hash is index 0 of a new block
//   success_i           - hash meets difficulty
//   nonce_prefix_i      - core nonce prefix
//   result_valid_o      - FIFO head holds a record
//   result_ready_i      - consumer accepts the head
//   result_nonce_o      - {prefix, index} of the head record
//   result_found_o      - 1 = winner, 0 = exhausted
//   result_block_o      - block sequence number of the head record
//   busy_o              - scanning a block
//   overflow_o          - sticky record-dropped flag
module lattice_result_collector #(
  parameter int COUNTBITS  = 6,
  parameter int PREFIXBITS = 4,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic                          newblock_i,
  input  logic                          success_i,
  input  logic [PREFIXBITS-1:0]         nonce_prefix_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [PREFIXBITS+COUNTBITS-1:0] result_nonce_o,
  output logic                          result_found_o,
  output logic [7:0]                    result_block_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = PREFIXBITS + COUNTBITS;
  localparam int RW = 1 + NW + 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [COUNTBITS-1:0] cnt_q, cnt_d;
  logic [7:0]           blk_q, blk_d;
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [RW-1:0]        mem_q [DEPTH];

  logic                 start;
  logic                 evaluate;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic [COUNTBITS-1:0] cur_idx;
  logic [RW-1:0]        rec;
  logic [RW-1:0]        head;

  // cnt_q holds the index the next in-block hash will carry
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    push     = 1'b0;
    rec      = '0;
    cur_idx  = cnt_q;
    evaluate = 1'b0;
    start    = valid_i && newblock_i;
    if (start) begin
      blk_d    = blk_q + 8'd1;
      cur_idx  = '0;
      evaluate = 1'b1;
    end else if (valid_i && state_q == SCAN) begin
      evaluate = 1'b1;
    end
    if (evaluate) begin
      cnt_d   = cur_idx + COUNTBITS'(1);
      state_d = SCAN;
      if (success_i) begin
        push    = 1'b1;
        rec     = {1'b1, nonce_prefix_i, cur_idx, blk_d};
        state_d = DONE;
      end else if (&cur_idx) begin
        push    = 1'b1;
        rec     = {1'b0, nonce_prefix_i, cur_idx, blk_d};
        state_d = DONE;
      end
    end
  end

  // A pop frees the slot this cycle, so push while full is fine then
  always_comb begin
    pop     = (count_q != '0) && result_ready_i;
    full    = count_q == (AW+1)'(DEPTH);
    wr_en   = push && (!full || pop);
    ovf_d   = ovf_q | (push && full && !pop);
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= 8'hFF;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= rec;
    end
  end

  // Fields are forced to zero when empty so stale storage never shows
  assign head           = mem_q[rd_q];
  assign result_valid_o = count_q != '0;
  assign {result_found_o, result_nonce_o, result_block_o} =
    result_valid_o ? head : '0;
  assign busy_o         = state_q == SCAN;
  assign overflow_o     = ovf_q;

endmodule

// File: doc/lattice_result_collector.md
# lattice_result_collector

Downstream stage of the last lattice core. Consumes the core's per-hash `valid`/`newBlock`/`success` stream and its fixed nonce prefix. Reconstructs the full nonce of the first winning hash in each block, or flags the block as exhausted. Queues one record per block in a small FIFO, which drains to the host-side result path over a valid/ready handshake.

## Interface
Parameters:
- `COUNTBITS`, 6: width of per-block hash index (nonce suffix).
- `PREFIXBITS`, 4: width of core nonce prefix.
- `DEPTH`, 4: result FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  one hash result presented this cycle.
- `newblock_i`  in  1  qualified by `valid_i`; this hash is index 0 of a new block.
- `success_i`  in  1  qualified by `valid_i`; hash meets difficulty.
- `nonce_prefix_i`  in  PREFIXBITS  core index; sampled with each valid hash.
- `result_valid_o`  out  1  FIFO head holds a record.
- `result_ready_i`  in  1  consumer accepts head this cycle.
- `result_nonce_o`  out  PREFIXBITS+COUNTBITS  {prefix, index} of the record.
- `result_found_o`  out  1  1 = winning nonce; 0 = block exhausted.
- `result_block_o`  out  8  block sequence number of the record.
- `busy_o`  out  1  state is SCAN.
- `overflow_o`  out  1  sticky; a record was dropped because the FIFO was full.

## Operation
- Block id register (8 bit): increments on every `valid_i && newblock_i` and wraps 255→0. The first block after reset has id 0; the register resets to 8'hFF.
- Index counter (COUNTBITS): loads 0 on `valid_i && newblock_i` and increments on every other `valid_i` in SCAN. The index of the current hash equals the counter value used for that hash.
- FSM states and transitions:
  - IDLE (reset state):
    - `valid_i && newblock_i` → evaluate hash 0 as in SCAN.
    - `valid_i` without `newblock_i` is ignored.
  - SCAN:
    - `valid_i && success_i` → push {found=1, nonce={nonce_prefix_i, index}, block id}; go to DONE.
    - Otherwise, a valid hash at index 2^COUNTBITS−1 → push {found=0, nonce={prefix, all-ones}, block id}; go to DONE.
    - Otherwise stay in SCAN.
  - DONE:
    - Further hashes of the block are ignored, including additional successes.
    - `valid_i && newblock_i` → restart as in IDLE.
- Mid-block `newblock_i` in SCAN abandons the current block with no record pushed. The new block starts at index 0 and the hash is evaluated the same cycle.
- Hash 0 with success pushes a found record with index 0.
- With COUNTBITS=1, hash 0 without success leaves the block in SCAN; hash 1 ends it.
- FIFO:
  - Push and pop in the same cycle are legal in every occupancy, including full.
  - Push while full with no pop drops the record and sets `overflow_o`.
  - `overflow_o` clears only on `rst`.
  - Pop occurs on `result_valid_o && result_ready_i`.
  - Record fields are stable while `result_valid_o` is high and not popped.

## Timing
- Reset values:
  - FSM = IDLE.
  - `result_valid_o`=0, `result_nonce_o`=0, `result_found_o`=0, `result_block_o`=0.
  - `busy_o`=0, `overflow_o`=0, FIFO empty.
- Reset applies immediately on `rst` assertion, including mid-block, with the FIFO contents discarded.
- Decision latency: a hash presented on cycle N that ends a block is written to the FIFO at the edge ending cycle N. On an empty FIFO, `result_valid_o`=1 during cycle N+1.
- `busy_o` rises the cycle after the `newblock_i` hash that enters SCAN and falls the cycle after the block-ending hash.
- Pop on cycle M: the next entry (if any) is presented on cycle M+1.
- Throughput: one input hash per cycle sustained. No backpressure to upstream; the only loss mechanism is overflow.

## Test plan
- **Found case:** `nonce_prefix_i`=4'h3, newblock at hash 0, success on hash 5, `result_ready_i`=1 → one record {nonce=10'h0C5, found=1, block=0}. `result_valid_o` is high exactly one cycle after the success hash.
- **Exhausted case:** prefix 4'h3, 64 valid hashes with no success → record {nonce=10'h0FF, found=0, block=0}. A success on hash 64+ without a newblock produces no record.
- **Backpressure and overflow:** `result_ready_i`=0 across 5 blocks, each with success at hash 0. FIFO holds blocks 0–3 and `overflow_o`=1. Then raise ready → records drain in block order 0,1,2,3 with fields stable while stalled.
- **Abandon:** newblock at hash 0, then 10 hashes, then newblock again, then success at index 2 → a single record with block=1, index 2. No record for block 0.
- **Full push+pop:** FIFO full, ready=1, and a new record pushed the same cycle → no overflow. Occupancy remains 4, and the order is preserved.
- **Reset mid-operation:** assert `rst` asynchronously in SCAN with 2 FIFO entries → all outputs 0 immediately. The next block is numbered 0, and hashes without newblock are ignored.
